// File: rtl/dmem_responder_if.sv
`default_nettype none
// ============================================================================
//  Module   : dmem_responder_if
//  Purpose  : Data-memory port between the core's memory stage (master) and
//             the memory responder (slave). Two independent valid/ready
//             channels: a request channel carrying one word access, and a
//             response channel returning read data plus an error flag.
//  Signals  :
//    req_valid  master->slave  request present
//    req_ready  slave->master  responder can accept a request
//    req_write  master->slave  1 = write, 0 = read
//    req_addr   master->slave  word address (not a byte address)
//    req_wdata  master->slave  write data
//    req_be     master->slave  byte enables, bit i selects bits [8i+7:8i]
//    rsp_valid  slave->master  response present
//    rsp_ready  master->slave  core accepts the response
//    rsp_rdata  slave->master  read data, 0 for writes and errors
//    rsp_err    slave->master  address was out of range
//  Revision : 1.0  initial release
// ============================================================================
interface dmem_responder_if;

  logic        req_valid;
  logic        req_ready;
  logic        req_write;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic [3:0]  req_be;

  logic        rsp_valid;
  logic        rsp_ready;
  logic [31:0] rsp_rdata;
  logic        rsp_err;

  // Core side: issues requests, consumes responses.
  modport master (
    output req_valid, req_write, req_addr, req_wdata, req_be, rsp_ready,
    input  req_ready, rsp_valid, rsp_rdata, rsp_err
  );

  // Memory side: accepts requests, produces responses.
  modport slave (
    input  req_valid, req_write, req_addr, req_wdata, req_be, rsp_ready,
    output req_ready, rsp_valid, rsp_rdata, rsp_err
  );

endinterface
`default_nettype wire

// File: rtl/dmem_responder.sv
`default_nettype none
// ============================================================================
//  Module   : dmem_responder
//  Purpose  : Responder end of the core's data-memory port. Holds a
//             2**ADDR_W x 32-bit word array built from four byte lanes,
//             services one read or write at a time, inserts LATENCY wait
//             states between accepting a request and presenting its
//             response, and flags accesses whose word address does not fit
//             in ADDR_W bits.
//  Ports    :
//    clk  in   clock, rising edge
//    clr  in   reset, asynchronous, active-low
//    bus  slave modport of dmem_responder_if (request + response channels)
//  Params   :
//    ADDR_W   word-address width, array depth is 2**ADDR_W words
//    LATENCY  wait-state cycles between accept and response (0..15)
//  Revision : 1.0  initial release
// ============================================================================
module dmem_responder #(
  parameter int ADDR_W  = 8,
  parameter int LATENCY = 2
) (
  input  logic             clk,
  input  logic             clr,
  dmem_responder_if.slave  bus
);

  localparam int          DEPTH   = 1 << ADDR_W;
  localparam logic [3:0]  LAT_CNT = 4'(LATENCY);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } state_t;

  // --------------------------------------------------------------------------
  // State and latched request
  // --------------------------------------------------------------------------
  state_t      state;
  logic [3:0]  cnt;
  logic        lat_write;
  logic [31:0] lat_addr;
  logic [31:0] lat_wdata;
  logic [3:0]  lat_be;

  logic        rsp_valid_q;
  logic [31:0] rsp_rdata_q;
  logic        rsp_err_q;

  // --------------------------------------------------------------------------
  // Request acceptance
  // --------------------------------------------------------------------------
  // req_ready is a decode of the state register rather than a separate flop
  // so that it is high in the very first IDLE cycle after reset release. The
  // clr term keeps it low for the whole time reset is asserted.
  logic can_accept;
  logic accept;

  assign can_accept = (state == IDLE) && clr;
  assign accept     = can_accept && bus.req_valid;

  // --------------------------------------------------------------------------
  // Access operands
  // --------------------------------------------------------------------------
  // With LATENCY=0 the access happens on the accept edge itself, so the
  // operands come straight from the bus. Otherwise they come from the
  // request latched at accept time. In WAIT/RESP the bus values are
  // irrelevant, which is why the mux selects on IDLE alone.
  logic        acc_write;
  logic [31:0] acc_addr;
  logic [31:0] acc_wdata;
  logic [3:0]  acc_be;
  logic        acc_err;
  logic [ADDR_W-1:0] acc_idx;

  always_comb begin
    acc_write = lat_write;
    acc_addr  = lat_addr;
    acc_wdata = lat_wdata;
    acc_be    = lat_be;
    if (state == IDLE) begin
      acc_write = bus.req_write;
      acc_addr  = bus.req_addr;
      acc_wdata = bus.req_wdata;
      acc_be    = bus.req_be;
    end
  end

  // Any set bit above the array's index range makes the access illegal.
  assign acc_err = |acc_addr[31:ADDR_W];
  assign acc_idx = acc_addr[ADDR_W-1:0];

  // The edge on which the array is actually touched and the response
  // registers are loaded.
  logic access_now;

  assign access_now = ((state == IDLE) && accept && (LAT_CNT == 4'd0)) ||
                      ((state == WAIT) && (cnt == 4'd1));

  // --------------------------------------------------------------------------
  // Byte-lane storage
  // --------------------------------------------------------------------------
  // Each lane is its own 8-bit array so a partial write only updates the
  // enabled bytes. The array is deliberately not reset. Write enables are
  // gated by clr so an aborted request can never commit.
  logic [31:0] rd_word;
  logic [3:0]  lane_we;

  assign lane_we = (access_now && acc_write && !acc_err && clr) ? acc_be : 4'b0000;

  for (genvar i = 0; i < 4; i++) begin : g_lane
    logic [7:0] lane_mem [0:DEPTH-1];

    always_ff @(posedge clk) begin
      if (lane_we[i]) begin
        lane_mem[acc_idx] <= acc_wdata[8*i +: 8];
      end
    end

    assign rd_word[8*i +: 8] = lane_mem[acc_idx];
  end

  // Writes and illegal addresses return zero data; byte enables play no
  // part in a read.
  logic [31:0] rd_result;

  assign rd_result = (!acc_write && !acc_err) ? rd_word : 32'd0;

  // --------------------------------------------------------------------------
  // Control FSM with registered response outputs
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or negedge clr) begin
    if (!clr) begin
      state       <= IDLE;
      cnt         <= 4'd0;
      lat_write   <= 1'b0;
      lat_addr    <= 32'd0;
      lat_wdata   <= 32'd0;
      lat_be      <= 4'd0;
      rsp_valid_q <= 1'b0;
      rsp_rdata_q <= 32'd0;
      rsp_err_q   <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (accept) begin
            lat_write <= bus.req_write;
            lat_addr  <= bus.req_addr;
            lat_wdata <= bus.req_wdata;
            lat_be    <= bus.req_be;
            cnt       <= LAT_CNT;
            if (LAT_CNT == 4'd0) begin
              // Zero wait states: the access completes on the accept edge.
              state       <= RESP;
              rsp_valid_q <= 1'b1;
              rsp_rdata_q <= rd_result;
              rsp_err_q   <= acc_err;
            end else begin
              state <= WAIT;
            end
          end
        end

        WAIT: begin
          cnt <= cnt - 4'd1;
          if (cnt == 4'd1) begin
            state       <= RESP;
            rsp_valid_q <= 1'b1;
            rsp_rdata_q <= rd_result;
            rsp_err_q   <= acc_err;
          end
        end

        RESP: begin
          // Data and error stay frozen until the core takes the response.
          if (bus.rsp_ready) begin
            rsp_valid_q <= 1'b0;
            state       <= IDLE;
          end
        end

        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

  // --------------------------------------------------------------------------
  // Output drive
  // --------------------------------------------------------------------------
  assign bus.req_ready = can_accept;
  assign bus.rsp_valid = rsp_valid_q;
  assign bus.rsp_rdata = rsp_rdata_q;
  assign bus.rsp_err   = rsp_err_q;

endmodule
`default_nettype wire

// File: tb/tb_dmem_responder.sv
`default_nettype none
// ============================================================================
//  Module   : tb_dmem_responder
//  Purpose  : Self-checking bench for dmem_responder. Three instances run
//             side by side with LATENCY = 2, 0 and 3 (ADDR_W = 8). Each is
//             driven through its own interface from per-instance bench
//             signals, and every response is compared with a word-array
//             reference model held in the bench.
//  Revision : 1.0  initial release
// ============================================================================
module tb_dmem_responder;

  localparam int NDUT  = 3;
  localparam int DEPTH = 256;

  logic clk;
  logic clr;

  // Per-instance stimulus and observation signals.
  logic        req_valid [NDUT];
  logic        req_write [NDUT];
  logic [31:0] req_addr  [NDUT];
  logic [31:0] req_wdata [NDUT];
  logic [3:0]  req_be    [NDUT];
  logic        rsp_ready [NDUT];
  logic        req_ready [NDUT];
  logic        rsp_valid [NDUT];
  logic [31:0] rsp_rdata [NDUT];
  logic        rsp_err   [NDUT];

  // Reference model: plain word array per instance.
  logic [31:0] ref_mem [NDUT][DEPTH];

  int n_tests = 0;
  int n_fail  = 0;

  function automatic int lat_of(input int d);
    case (d)
      0:       return 2;
      1:       return 0;
      default: return 3;
    endcase
  endfunction

  for (genvar g = 0; g < NDUT; g++) begin : g_dut
    localparam int LAT = (g == 0) ? 2 : (g == 1) ? 0 : 3;

    dmem_responder_if bus ();

    assign bus.req_valid = req_valid[g];
    assign bus.req_write = req_write[g];
    assign bus.req_addr  = req_addr[g];
    assign bus.req_wdata = req_wdata[g];
    assign bus.req_be    = req_be[g];
    assign bus.rsp_ready = rsp_ready[g];
    assign req_ready[g]  = bus.req_ready;
    assign rsp_valid[g]  = bus.rsp_valid;
    assign rsp_rdata[g]  = bus.rsp_rdata;
    assign rsp_err[g]    = bus.rsp_err;

    dmem_responder #(
      .ADDR_W  (8),
      .LATENCY (LAT)
    ) u_dut (
      .clk (clk),
      .clr (clr),
      .bus (bus)
    );
  end

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, got, exp);
    end
  endtask

  // One complete transaction on instance d: accept, wait-state count,
  // response content, optional backpressure, handshake.
  task automatic txn(input int d, input bit wr, input logic [31:0] addr,
                     input logic [31:0] wdata, input logic [3:0] be, input int stall);
    logic        exp_err;
    logic [31:0] exp_rdata;
    int          guard;
    int          n;
    int          busy_ready;
    int          unstable;
    string       pfx;

    pfx       = $sformatf("d%0d %s a=%0h", d, wr ? "wr" : "rd", addr);
    exp_err   = (addr >= 32'(DEPTH));
    exp_rdata = (!wr && !exp_err) ? ref_mem[d][addr[7:0]] : 32'd0;
    if (wr && !exp_err) begin
      for (int i = 0; i < 4; i++) begin
        if (be[i]) ref_mem[d][addr[7:0]][8*i +: 8] = wdata[8*i +: 8];
      end
    end

    @(negedge clk);
    req_valid[d] = 1'b1;
    req_write[d] = wr;
    req_addr[d]  = addr;
    req_wdata[d] = wdata;
    req_be[d]    = be;
    guard = 0;
    while (!req_ready[d] && guard < 50) begin
      @(negedge clk);
      guard++;
    end
    check_eq({pfx, " accept_delay"}, 32'(guard), 32'd0);

    // Accept happens at the coming rising edge.
    @(negedge clk);
    req_valid[d] = 1'b0;
    req_addr[d]  = $urandom;
    req_wdata[d] = $urandom;
    n = 1;
    busy_ready = 0;
    while (!rsp_valid[d] && n < 40) begin
      if (req_ready[d]) busy_ready++;
      @(negedge clk);
      n++;
    end
    if (req_ready[d]) busy_ready++;
    check_eq({pfx, " latency"}, 32'(n), 32'(lat_of(d) + 1));
    check_eq({pfx, " ready_while_busy"}, 32'(busy_ready), 32'd0);
    check_eq({pfx, " rdata"}, rsp_rdata[d], exp_rdata);
    check_eq({pfx, " err"}, 32'(rsp_err[d]), 32'(exp_err));

    unstable = 0;
    for (int i = 0; i < stall; i++) begin
      @(negedge clk);
      if (rsp_valid[d] !== 1'b1 || rsp_rdata[d] !== exp_rdata ||
          rsp_err[d] !== exp_err || req_ready[d] !== 1'b0) unstable++;
    end
    if (stall > 0) check_eq({pfx, " stall_stable"}, 32'(unstable), 32'd0);

    rsp_ready[d] = 1'b1;
    @(negedge clk);
    rsp_ready[d] = 1'b0;
    check_eq({pfx, " valid_drop"}, 32'(rsp_valid[d]), 32'd0);
    check_eq({pfx, " ready_back"}, 32'(req_ready[d]), 32'd1);
  endtask

  function automatic logic [31:0] rand_addr();
    case ($urandom_range(0, 9))
      0:       return 32'd255;
      1:       return 32'd256;
      2:       return $urandom | 32'h0000_0100;
      default: return 32'($urandom_range(0, 15));
    endcase
  endfunction

  initial begin : main
    logic [31:0] old;
    int          acc_cyc [2];
    int          rsp_cyc [2];
    int          acc_n;
    int          rsp_n;
    bit          acc_now;
    logic [31:0] exp_seq [2];

    for (int d = 0; d < NDUT; d++) begin
      req_valid[d] = 1'b0;
      req_write[d] = 1'b0;
      req_addr[d]  = 32'd0;
      req_wdata[d] = 32'd0;
      req_be[d]    = 4'd0;
      rsp_ready[d] = 1'b0;
    end

    // Reset values
    clr = 1'b1;
    #2 clr = 1'b0;
    repeat (3) @(negedge clk);
    for (int d = 0; d < NDUT; d++) begin
      check_eq($sformatf("d%0d reset req_ready", d), 32'(req_ready[d]), 32'd0);
      check_eq($sformatf("d%0d reset rsp_valid", d), 32'(rsp_valid[d]), 32'd0);
      check_eq($sformatf("d%0d reset rsp_rdata", d), rsp_rdata[d], 32'd0);
      check_eq($sformatf("d%0d reset rsp_err", d), 32'(rsp_err[d]), 32'd0);
    end
    clr = 1'b1;
    @(negedge clk);
    for (int d = 0; d < NDUT; d++) begin
      check_eq($sformatf("d%0d idle req_ready", d), 32'(req_ready[d]), 32'd1);
    end

    // Give every word the random tests touch a known value.
    for (int d = 0; d < NDUT; d++) begin
      for (int a = 0; a < 16; a++) txn(d, 1'b1, 32'(a), $urandom, 4'hF, 0);
      txn(d, 1'b1, 32'd255, $urandom, 4'hF, 0);
    end

    // Directed: full write, read, partial write, backpressure (LATENCY=2).
    txn(0, 1'b1, 32'd5, 32'hDEAD_BEEF, 4'b1111, 0);
    txn(0, 1'b0, 32'd5, 32'd0, 4'b0000, 0);
    check_eq("d0 model deadbeef", ref_mem[0][5], 32'hDEAD_BEEF);
    txn(0, 1'b1, 32'd5, 32'h0000_00AA, 4'b0001, 0);
    txn(0, 1'b0, 32'd5, 32'd0, 4'b1111, 5);
    check_eq("d0 model deadbeaa", ref_mem[0][5], 32'hDEAD_BEAA);

    // Out of range write must leave the array alone; boundaries.
    old = ref_mem[0][0];
    txn(0, 1'b1, 32'h100, 32'h1234_5678, 4'b1111, 0);
    txn(0, 1'b0, 32'h0, 32'd0, 4'b0000, 0);
    check_eq("d0 model word0 kept", ref_mem[0][0], old);
    txn(0, 1'b0, 32'd255, 32'd0, 4'b0000, 0);
    txn(0, 1'b0, 32'd256, 32'd0, 4'b0000, 0);
    txn(0, 1'b1, 32'd3, 32'hFFFF_FFFF, 4'b0000, 1);
    txn(0, 1'b0, 32'd3, 32'd0, 4'b0000, 0);

    // LATENCY=0 back-to-back reads with rsp_ready held high.
    exp_seq[0] = ref_mem[1][1];
    exp_seq[1] = ref_mem[1][2];
    @(negedge clk);
    rsp_ready[1] = 1'b1;
    req_valid[1] = 1'b1;
    req_write[1] = 1'b0;
    req_addr[1]  = 32'd1;
    req_be[1]    = 4'd0;
    acc_n = 0;
    rsp_n = 0;
    acc_cyc = '{-100, -100};
    rsp_cyc = '{0, 0};
    for (int c = 0; c < 12 && rsp_n < 2; c++) begin
      acc_now = 1'b0;
      if (rsp_valid[1] && rsp_n < 2) begin
        check_eq($sformatf("d1 b2b rdata%0d", rsp_n), rsp_rdata[1], exp_seq[rsp_n]);
        rsp_cyc[rsp_n] = c;
        rsp_n++;
      end
      if (req_valid[1] && req_ready[1] && acc_n < 2) begin
        acc_cyc[acc_n] = c;
        acc_n++;
        acc_now = 1'b1;
      end
      @(negedge clk);
      if (acc_now) begin
        if (acc_n == 1) req_addr[1] = 32'd2;
        else            req_valid[1] = 1'b0;
      end
    end
    @(negedge clk);
    rsp_ready[1] = 1'b0;
    req_valid[1] = 1'b0;
    check_eq("d1 b2b responses", 32'(rsp_n), 32'd2);
    check_eq("d1 b2b spacing", 32'(acc_cyc[1] - acc_cyc[0]), 32'd2);
    check_eq("d1 b2b lat0", 32'(rsp_cyc[0] - acc_cyc[0]), 32'd1);
    check_eq("d1 b2b lat1", 32'(rsp_cyc[1] - acc_cyc[1]), 32'd1);

    // Reset while a LATENCY=3 write is waiting: the write must not land.
    txn(2, 1'b0, 32'd9, 32'd0, 4'b0000, 0);
    old = ref_mem[2][7];
    @(negedge clk);
    req_valid[2] = 1'b1;
    req_write[2] = 1'b1;
    req_addr[2]  = 32'd7;
    req_wdata[2] = ~old;
    req_be[2]    = 4'hF;
    check_eq("d2 abort accept", 32'(req_ready[2]), 32'd1);
    @(negedge clk);
    req_valid[2] = 1'b0;
    clr = 1'b0;
    #1;
    check_eq("d2 abort req_ready", 32'(req_ready[2]), 32'd0);
    check_eq("d2 abort rsp_valid", 32'(rsp_valid[2]), 32'd0);
    check_eq("d2 abort rsp_rdata", rsp_rdata[2], 32'd0);
    check_eq("d2 abort rsp_err", 32'(rsp_err[2]), 32'd0);
    repeat (2) @(negedge clk);
    clr = 1'b1;
    @(negedge clk);
    txn(2, 1'b0, 32'd7, 32'd0, 4'b0000, 0);

    // Randomized traffic on every instance.
    for (int d = 0; d < NDUT; d++) begin
      for (int k = 0; k < 40; k++) begin
        txn(d, 1'($urandom_range(0, 1)), rand_addr(), $urandom,
            4'($urandom_range(0, 15)), $urandom_range(0, 3));
      end
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  // Hard stop in case a bounded loop is ever defeated.
  initial begin : watchdog
    #2000000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
`default_nettype wire

// File: doc/dmem_responder.md
Name: dmem_responder

Overview:
- Responder end of the pipeline's data-memory port: services word read/write requests issued by the core's memory stage over a valid/ready request channel and a valid/ready response channel.
- Holds a word-addressed array built as four byte lanes, inserts a programmable number of wait states, and flags out-of-range accesses.
- Replaces the zero-latency combinational data memory so the core can be exercised against realistic memory latency.

Parameters:
- ADDR_W, 8, word-address width; array depth is 2**ADDR_W 32-bit words.
- LATENCY, 2, wait-state cycles between request accept and response presentation (0..15).

Ports:
- clk  in  1  clock, rising edge.
- clr  in  1  reset, asynchronous, active-low.
- req_valid  in  1  request present.
- req_ready  out  1  responder can accept a request.
- req_write  in  1  1 = write, 0 = read.
- req_addr  in  32  word address (ALU result, not byte address).
- req_wdata  in  32  write data.
- req_be  in  4  byte enables; bit i selects lane bits [8i+7:8i].
- rsp_valid  out  1  response present.
- rsp_ready  in  1  core accepts response.
- rsp_rdata  out  32  read data; 0 for writes and errors.
- rsp_err  out  1  address out of range.

Behaviour:
- Reset (clr low, any time): state IDLE, req_ready=0 during reset then 1 in IDLE, rsp_valid=0, rsp_rdata=0, rsp_err=0, wait counter=0, latched request cleared. Array contents are not reset. A request in flight is aborted, and an uncommitted write never reaches the array.
- FSM states: IDLE, WAIT, RESP.
- IDLE:
  - req_ready=1.
  - On req_valid&&req_ready, latch write, addr, wdata and be; load counter with LATENCY.
  - Go to WAIT if LATENCY>0, else to RESP with the access performed at this edge.
- WAIT:
  - req_ready=0; counter decrements each cycle.
  - On the edge where counter==1, perform the access and go to RESP.
- Access:
  - err = |addr[31:ADDR_W].
  - Write with !err: update only enabled lanes of array[addr[ADDR_W-1:0]].
  - Read with !err: rsp_rdata = full word; be is ignored for reads.
  - Write or err: rsp_rdata=0.
  - err: no array update.
- RESP:
  - rsp_valid=1; rsp_rdata and rsp_err are held stable until rsp_valid&&rsp_ready.
  - At that edge, rsp_valid drops to 0 and state goes to IDLE.
- Latency:
  - Accept edge to rsp_valid high is LATENCY+1 cycles (1 cycle when LATENCY=0).
  - Minimum request-to-request spacing is LATENCY+2 cycles.
  - At most one outstanding request.
- Ordering: a read accepted after a write's response completes returns the written data.
- req_valid while req_ready=0 is ignored; requester holds request stable until accepted.
- rsp_ready asserted while rsp_valid=0 has no effect.
- req_be=0 write: no lanes change; a normal response is still returned.
- Address exactly 2**ADDR_W-1 is legal. Address 2**ADDR_W sets rsp_err.

Test Plan:
- LATENCY=2: write addr 5, wdata 0xDEADBEEF, be=1111; read addr 5 -> rsp_valid 3 cycles after each accept, read rsp_rdata=0xDEADBEEF, rsp_err=0.
- Partial write: after the above, write addr 5, wdata 0x000000AA, be=0001; read addr 5 -> rsp_rdata=0xDEADBEAA.
- Backpressure: read accepted, rsp_ready held 0 for 5 cycles -> rsp_valid and rsp_rdata stable throughout; req_ready stays 0; completes on first rsp_ready=1 edge.
- Out of range, ADDR_W=8: write addr 0x100 wdata 0x12345678 -> rsp_err=1; then read addr 0x00 -> original contents unchanged, rsp_err=0.
- LATENCY=0: back-to-back reads addr 1, 2 with rsp_ready tied 1 -> rsp_valid one cycle after each accept; accepts spaced 2 cycles apart.
- Reset mid-WAIT: write accepted with LATENCY=3, clr pulled low one cycle later -> outputs go to reset values immediately; subsequent read of that address returns its prior value.
